// File: rtl/dcache_st_port_pkg.sv
// dcache_st_port_pkg
//   Shared definitions for the D$ store port:
//   - st_state_e  : store FSM states (IDLE, LOOKUP, WRITE, MEM)
//   - D$ geometry : 8 KB direct-mapped, 32-byte lines, 64-bit words
//   - dc_tag_hit(): tag-compare helper used in the LOOKUP state
package dcache_st_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WRITE  = 2'd2,
    ST_MEM    = 2'd3
  } st_state_e;

  // Address slicing: [2:0] byte in word, [4:3] word in line,
  // [12:5] line index, [12:3] word index, [VA_W-1:13] tag.
  localparam int DC_WORD_LSB   = 3;
  localparam int DC_LINE_LSB   = 5;
  localparam int DC_TAG_LSB    = 13;
  localparam int DC_LINE_IDX_W = DC_TAG_LSB - DC_LINE_LSB;  // 8
  localparam int DC_WORD_IDX_W = DC_TAG_LSB - DC_WORD_LSB;  // 10
  localparam int DC_BE_W       = 8;
  localparam int DC_DATA_W     = 64;

  // Tags are passed zero-extended to 64 bits so one helper serves any VA_W.
  function automatic logic dc_tag_hit(input logic        tag_vld,
                                      input logic [63:0] rd_tag,
                                      input logic [63:0] st_tag);
    return tag_vld && (rd_tag == st_tag);
  endfunction

endpackage

// File: rtl/dc_st_hazard.sv
// dc_st_hazard
//   Load/store hazard comparator at 8-byte word granularity. A load hazards
//   against the store held by the FSM (busy_i) or against the request
//   currently offered by the store buffer.
//   Ports:
//     ld_req_i      load pipe request this cycle
//     ld_word_i     load address word number (va[VA_W-1:3])
//     busy_i        store FSM holds an un-retired store
//     lat_word_i    word number of the held store
//     st_vld_i      store buffer offers a request
//     st_word_i     word number of the offered request
//     hazard_o      load must wait for the store
module dc_st_hazard #(
  parameter int WORD_W = 45
) (
  input  logic              ld_req_i,
  input  logic [WORD_W-1:0] ld_word_i,
  input  logic              busy_i,
  input  logic [WORD_W-1:0] lat_word_i,
  input  logic              st_vld_i,
  input  logic [WORD_W-1:0] st_word_i,
  output logic              hazard_o
);

  logic lat_match;
  logic st_match;

  assign lat_match = busy_i   && (lat_word_i == ld_word_i);
  assign st_match  = st_vld_i && (st_word_i  == ld_word_i);
  assign hazard_o  = ld_req_i && (lat_match || st_match);

endmodule

// File: rtl/dcache_st_port.sv
// dcache_st_port
//   Write-through, no-write-allocate store port for an 8 KB direct-mapped
//   D$. One store in flight: IDLE samples a request and reads the tag,
//   LOOKUP compares, WRITE updates the data array on a hit, MEM issues the
//   write-through and retires the store on the memory handshake.
//   The load pipe owns the D$ arrays whenever ld_req_e0 is high.
//   Ports:
//     clk, reset_n                  clock, async active-low reset
//     rtr_st_*_xx                   store request in / ack pulse out
//     ld_req_e0, ld_va_e0           load pipe array ownership + address
//     ld_st_hazard_e0               load word overlaps an un-retired store
//     dc_tag_rd_en/idx, dc_tag_vld/dc_tag   tag array read / result
//     dc_wr_en/idx/be/data          data array word write
//     mem_wr_vld/addr/be/data/rdy   write-through request to memory
`ifndef VA_BITS
`define VA_BITS 48
`endif

module dcache_st_port
  import dcache_st_port_pkg::*;
#(
  parameter int VA_W = `VA_BITS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  // store buffer
  input  logic                     rtr_st_vld_xx,
  input  logic [DC_BE_W-1:0]       rtr_st_be_xx,
  input  logic [DC_DATA_W-1:0]     rtr_st_data_xx,
  input  logic [VA_W-1:0]          rtr_st_addr_xx,
  output logic                     rtr_st_ack_xx,
  // load pipe
  input  logic                     ld_req_e0,
  input  logic [VA_W-1:0]          ld_va_e0,
  output logic                     ld_st_hazard_e0,
  // tag array
  output logic                     dc_tag_rd_en,
  output logic [DC_LINE_IDX_W-1:0] dc_tag_idx,
  input  logic                     dc_tag_vld,
  input  logic [VA_W-14:0]         dc_tag,
  // data array
  output logic                     dc_wr_en,
  output logic [DC_WORD_IDX_W-1:0] dc_wr_idx,
  output logic [DC_BE_W-1:0]       dc_wr_be,
  output logic [DC_DATA_W-1:0]     dc_wr_data,
  // memory
  output logic                     mem_wr_vld,
  output logic [VA_W-1:0]          mem_wr_addr,
  output logic [DC_BE_W-1:0]       mem_wr_be,
  output logic [DC_DATA_W-1:0]     mem_wr_data,
  input  logic                     mem_wr_rdy
);

  st_state_e              state_q;
  logic [VA_W-1:0]        addr_q;
  logic [DC_BE_W-1:0]     be_q;
  logic [DC_DATA_W-1:0]   data_q;

  logic accept;
  logic hit;
  logic unused_ld_va_lo;

  // Loads have priority for the arrays, so a store is only sampled when
  // the load pipe leaves the tag array free this cycle.
  assign accept = (state_q == ST_IDLE) && rtr_st_vld_xx && !ld_req_e0;

  assign hit = dc_tag_hit(dc_tag_vld, 64'(dc_tag),
                          64'(addr_q[VA_W-1:DC_TAG_LSB]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= rtr_st_addr_xx;
            be_q    <= rtr_st_be_xx;
            data_q  <= rtr_st_data_xx;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: state_q <= hit ? ST_WRITE : ST_MEM;
        ST_WRITE: begin
          if (!ld_req_e0) state_q <= ST_MEM;
        end
        ST_MEM: begin
          if (mem_wr_rdy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The tag read is issued in the sampling cycle itself; gating with
  // reset_n keeps it quiet while reset holds the FSM in IDLE.
  assign dc_tag_rd_en = accept && reset_n;
  assign dc_tag_idx   = rtr_st_addr_xx[DC_TAG_LSB-1:DC_LINE_LSB];

  assign dc_wr_en   = (state_q == ST_WRITE) && !ld_req_e0;
  assign dc_wr_idx  = addr_q[DC_TAG_LSB-1:DC_WORD_LSB];
  assign dc_wr_be   = be_q;
  assign dc_wr_data = data_q;

  assign mem_wr_vld  = (state_q == ST_MEM);
  assign mem_wr_addr = addr_q;
  assign mem_wr_be   = be_q;
  assign mem_wr_data = data_q;

  assign rtr_st_ack_xx = mem_wr_vld && mem_wr_rdy;

  // Hazards are word-granular; the byte offset of the load is irrelevant.
  assign unused_ld_va_lo = ^ld_va_e0[DC_WORD_LSB-1:0];

  dc_st_hazard #(
    .WORD_W (VA_W - DC_WORD_LSB)
  ) u_hazard (
    .ld_req_i   (ld_req_e0),
    .ld_word_i  (ld_va_e0[VA_W-1:DC_WORD_LSB]),
    .busy_i     (state_q != ST_IDLE),
    .lat_word_i (addr_q[VA_W-1:DC_WORD_LSB]),
    .st_vld_i   (rtr_st_vld_xx),
    .st_word_i  (rtr_st_addr_xx[VA_W-1:DC_WORD_LSB]),
    .hazard_o   (ld_st_hazard_e0)
  );

endmodule

// File: tb/tb_dcache_st_port.sv
// tb_dcache_st_port
//   Table-driven checks of the idle-state combinational outputs, scripted
//   multi-cycle corner cases, then randomized traffic checked against a
//   transaction-level model of the store port and a model of the tag array.
module tb_dcache_st_port;

  localparam int VA_W  = 32;
  localparam int TAG_W = VA_W - 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             rtr_st_vld_xx;
  logic [7:0]       rtr_st_be_xx;
  logic [63:0]      rtr_st_data_xx;
  logic [VA_W-1:0]  rtr_st_addr_xx;
  logic             rtr_st_ack_xx;
  logic             ld_req_e0;
  logic [VA_W-1:0]  ld_va_e0;
  logic             ld_st_hazard_e0;
  logic             dc_tag_rd_en;
  logic [7:0]       dc_tag_idx;
  logic             dc_tag_vld;
  logic [TAG_W-1:0] dc_tag;
  logic             dc_wr_en;
  logic [9:0]       dc_wr_idx;
  logic [7:0]       dc_wr_be;
  logic [63:0]      dc_wr_data;
  logic             mem_wr_vld;
  logic [VA_W-1:0]  mem_wr_addr;
  logic [7:0]       mem_wr_be;
  logic [63:0]      mem_wr_data;
  logic             mem_wr_rdy;

  dcache_st_port #(.VA_W(VA_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rtr_st_vld_xx   (rtr_st_vld_xx),
    .rtr_st_be_xx    (rtr_st_be_xx),
    .rtr_st_data_xx  (rtr_st_data_xx),
    .rtr_st_addr_xx  (rtr_st_addr_xx),
    .rtr_st_ack_xx   (rtr_st_ack_xx),
    .ld_req_e0       (ld_req_e0),
    .ld_va_e0        (ld_va_e0),
    .ld_st_hazard_e0 (ld_st_hazard_e0),
    .dc_tag_rd_en    (dc_tag_rd_en),
    .dc_tag_idx      (dc_tag_idx),
    .dc_tag_vld      (dc_tag_vld),
    .dc_tag          (dc_tag),
    .dc_wr_en        (dc_wr_en),
    .dc_wr_idx       (dc_wr_idx),
    .dc_wr_be        (dc_wr_be),
    .dc_wr_data      (dc_wr_data),
    .mem_wr_vld      (mem_wr_vld),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_be       (mem_wr_be),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_rdy      (mem_wr_rdy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // tag array contents seen by the port
  logic             tv [256];
  logic [TAG_W-1:0] tt [256];

  // transaction-level model: one store in flight, age counts cycles since
  // it was sampled (1 = tag result cycle)
  bit              m_busy;
  int              m_age;
  bit              m_hit;
  bit              m_wrote;
  bit              m_acked;
  logic [VA_W-1:0] m_addr;
  logic [7:0]      m_be;
  logic [63:0]     m_data;
  int              n_txn = 0;

  // observed event times
  int         cyc = 0;
  int         cyc_rd, cyc_wr, cyc_mem, cyc_ack;
  int         n_wr = 0, n_ack = 0;
  bit         prev_mem = 1'b0;
  logic [9:0] last_wr_idx;

  typedef struct {
    logic            ld_req;
    logic [VA_W-1:0] ld_va;
    logic            st_vld;
    logic [VA_W-1:0] st_addr;
    logic            exp_hz;
    logic            exp_rd;
    logic [7:0]      exp_idx;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_age   = 0;
    m_hit   = 1'b0;
    m_wrote = 1'b0;
    m_acked = 1'b0;
  endtask

  function automatic logic [VA_W-1:0] rand_addr();
    logic [VA_W-1:0] a;
    a = (($urandom % 2) != 0 ? 32'd5 : 32'd9) << 13;
    a = a | (32'($urandom % 4) << 5);
    a = a | 32'($urandom % 32);
    return a;
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the
  // rising edge, then answer any tag read like a synchronous RAM.
  task automatic cycle();
    bit         e_rd, e_wr, e_mem, e_ack, e_hz;
    bit         s_rd;
    logic [7:0] s_idx;
    @(negedge clk);
    e_rd  = !m_busy && rtr_st_vld_xx && !ld_req_e0;
    e_wr  = m_busy && m_hit && !m_wrote && (m_age >= 2) && !ld_req_e0;
    e_mem = m_busy && (m_age >= 2) && (!m_hit || m_wrote);
    e_ack = e_mem && mem_wr_rdy;
    e_hz  = ld_req_e0 &&
            ((m_busy && (m_addr[VA_W-1:3] == ld_va_e0[VA_W-1:3])) ||
             (rtr_st_vld_xx && (rtr_st_addr_xx[VA_W-1:3] == ld_va_e0[VA_W-1:3])));
    chk("tag_rd_en", 64'(dc_tag_rd_en), 64'(e_rd));
    chk("dc_wr_en", 64'(dc_wr_en), 64'(e_wr));
    chk("mem_wr_vld", 64'(mem_wr_vld), 64'(e_mem));
    chk("ack", 64'(rtr_st_ack_xx), 64'(e_ack));
    chk("hazard", 64'(ld_st_hazard_e0), 64'(e_hz));
    if (e_rd) chk("tag_idx", 64'(dc_tag_idx), 64'(rtr_st_addr_xx[12:5]));
    if (e_wr) begin
      chk("wr_idx", 64'(dc_wr_idx), 64'(m_addr[12:3]));
      chk("wr_be", 64'(dc_wr_be), 64'(m_be));
      chk("wr_data", dc_wr_data, m_data);
    end
    if (e_mem) begin
      chk("mem_addr", 64'(mem_wr_addr), 64'(m_addr));
      chk("mem_be", 64'(mem_wr_be), 64'(m_be));
      chk("mem_data", mem_wr_data, m_data);
    end
    s_rd  = dc_tag_rd_en;
    s_idx = dc_tag_idx;
    if (dc_tag_rd_en) cyc_rd = cyc;
    if (dc_wr_en) begin
      cyc_wr = cyc;
      n_wr++;
      last_wr_idx = dc_wr_idx;
    end
    if (mem_wr_vld && !prev_mem) cyc_mem = cyc;
    prev_mem = mem_wr_vld;
    if (rtr_st_ack_xx) begin
      cyc_ack = cyc;
      n_ack++;
    end
    @(posedge clk);
    m_acked = 1'b0;
    if (!m_busy) begin
      if (e_rd) begin
        m_busy  = 1'b1;
        m_age   = 1;
        m_addr  = rtr_st_addr_xx;
        m_be    = rtr_st_be_xx;
        m_data  = rtr_st_data_xx;
        m_wrote = 1'b0;
        m_hit   = tv[m_addr[12:5]] && (tt[m_addr[12:5]] == m_addr[VA_W-1:13]);
      end
    end else if (e_ack) begin
      m_busy  = 1'b0;
      m_acked = 1'b1;
      n_txn++;
      $display("txn %0d: store addr=%h be=%h %s retired at cycle %0d",
               n_txn, m_addr, m_be, m_hit ? "hit" : "miss", cyc);
    end else begin
      if (e_wr) m_wrote = 1'b1;
      m_age++;
    end
    cyc++;
    #1;
    if (s_rd) begin
      dc_tag_vld = tv[s_idx];
      dc_tag     = tt[s_idx];
    end else begin
      dc_tag_vld = ($urandom % 2) != 0;
      dc_tag     = TAG_W'($urandom);
    end
  endtask

  task automatic run_until_ack(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      cycle();
      if (m_acked) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL ack_timeout: no ack within %0d cycles, ack required", max_cyc);
  endtask

  task automatic present(input logic [VA_W-1:0] a, input logic [7:0] be, input logic [63:0] d);
    rtr_st_vld_xx  = 1'b1;
    rtr_st_addr_xx = a;
    rtr_st_be_xx   = be;
    rtr_st_data_xx = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wr0, n_ack0;

    vecs[0] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_2008, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 32'h0000_2008, 1'b1, 32'h0000_2008, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 32'h0000_200F, 1'b1, 32'h0000_2008, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 32'h0000_2010, 1'b1, 32'h0000_2008, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 32'h0000_2008, 1'b0, 32'h0000_2008, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 32'h0000_2008, 1'b1, 32'h0000_1FE0, 1'b0, 1'b1, 8'hFF};
    vecs[6] = '{1'b0, 32'h0000_2008, 1'b0, 32'h0000_1FE0, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{1'b1, 32'h1234_5678, 1'b1, 32'h1234_567C, 1'b1, 1'b0, 8'h00};
    vecs[8] = '{1'b0, 32'h0000_0000, 1'b1, 32'hABCD_E0A0, 1'b0, 1'b1, 8'h05};

    for (int i = 0; i < 256; i++) begin
      tv[i] = 1'b0;
      tt[i] = '0;
    end
    reset_n        = 1'b0;
    rtr_st_vld_xx  = 1'b1;
    rtr_st_addr_xx = 32'h0000_2008;
    rtr_st_be_xx   = 8'hFF;
    rtr_st_data_xx = 64'h0;
    ld_req_e0      = 1'b0;
    ld_va_e0       = '0;
    dc_tag_vld     = 1'b0;
    dc_tag         = '0;
    mem_wr_rdy     = 1'b1;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_vld", 64'(mem_wr_vld), 64'd0);
    chk("rst_wr_en", 64'(dc_wr_en), 64'd0);
    chk("rst_ack", 64'(rtr_st_ack_xx), 64'd0);
    chk("rst_tag_rd", 64'(dc_tag_rd_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_wr_addr), 64'd0);
    chk("rst_mem_be", 64'(mem_wr_be), 64'd0);
    chk("rst_wr_data", dc_wr_data, 64'd0);
    rtr_st_vld_xx = 1'b0;
    reset_n       = 1'b1;
    cycle();

    // idle-state combinational outputs
    for (int i = 0; i < NV; i++) begin
      ld_req_e0      = vecs[i].ld_req;
      ld_va_e0       = vecs[i].ld_va;
      rtr_st_vld_xx  = vecs[i].st_vld;
      rtr_st_addr_xx = vecs[i].st_addr;
      #2;
      chk("vec_hazard", 64'(ld_st_hazard_e0), 64'(vecs[i].exp_hz));
      chk("vec_tag_rd", 64'(dc_tag_rd_en), 64'(vecs[i].exp_rd));
      if (vecs[i].exp_rd) chk("vec_tag_idx", 64'(dc_tag_idx), 64'(vecs[i].exp_idx));
      rtr_st_vld_xx = 1'b0;
      ld_req_e0     = 1'b0;
      @(posedge clk);
      #1;
    end

    // hit at 0x2008, be 0x0F
    tt[0] = TAG_W'(1);
    tv[0] = 1'b1;
    mem_wr_rdy = 1'b1;
    ld_va_e0   = '0;
    n_wr0 = n_wr;
    present(32'h0000_2008, 8'h0F, 64'h1122_3344_5566_7788);
    run_until_ack(20);
    rtr_st_vld_xx = 1'b0;
    chk("hit_wr_latency", 64'(cyc_wr - cyc_rd), 64'd2);
    chk("hit_ack_latency", 64'(cyc_ack - cyc_rd), 64'd3);
    chk("hit_wr_count", 64'(n_wr - n_wr0), 64'd1);
    chk("hit_wr_idx", 64'(last_wr_idx), 64'h001);

    // miss: same line, different tag
    n_wr0 = n_wr;
    present(32'h0000_4010, 8'hF0, 64'hDEAD_BEEF_0BAD_F00D);
    run_until_ack(20);
    rtr_st_vld_xx = 1'b0;
    chk("miss_mem_latency", 64'(cyc_mem - cyc_rd), 64'd2);
    chk("miss_wr_count", 64'(n_wr - n_wr0), 64'd0);

    // be == 0 store still traverses and retires
    n_ack0 = n_ack;
    present(32'h0000_2008, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
    run_until_ack(20);
    rtr_st_vld_xx = 1'b0;
    chk("be0_ack_count", 64'(n_ack - n_ack0), 64'd1);

    // load conflict in IDLE and in WRITE
    n_wr0 = n_wr;
    present(32'h0000_2010, 8'hA5, 64'h0123_4567_89AB_CDEF);
    ld_req_e0 = 1'b1;
    repeat (3) cycle();
    ld_req_e0 = 1'b0;
    cycle();
    cycle();
    ld_req_e0 = 1'b1;
    repeat (3) cycle();
    ld_req_e0 = 1'b0;
    run_until_ack(20);
    rtr_st_vld_xx = 1'b0;
    chk("ldc_wr_latency", 64'(cyc_wr - cyc_rd), 64'd5);
    chk("ldc_wr_count", 64'(n_wr - n_wr0), 64'd1);

    // backpressure: 5 cycles of mem_wr_rdy low, store buffer inputs churn
    mem_wr_rdy = 1'b0;
    n_ack0 = n_ack;
    present(32'h0000_4018, 8'h3C, 64'hCAFE_F00D_1234_5678);
    cycle();
    cycle();
    for (int i = 0; i < 5; i++) begin
      rtr_st_addr_xx = rand_addr();
      rtr_st_be_xx   = 8'($urandom);
      rtr_st_data_xx = {$urandom, $urandom};
      cycle();
    end
    chk("bp_no_ack", 64'(n_ack - n_ack0), 64'd0);
    mem_wr_rdy = 1'b1;
    run_until_ack(5);
    rtr_st_vld_xx = 1'b0;
    chk("bp_ack_latency", 64'(cyc_ack - cyc_rd), 64'd7);

    // hazard against the store held in MEM
    mem_wr_rdy = 1'b0;
    present(32'h0000_1000, 8'hFF, 64'h5555_AAAA_5555_AAAA);
    cycle();
    cycle();
    rtr_st_vld_xx = 1'b0;
    ld_req_e0     = 1'b1;
    ld_va_e0      = 32'h0000_1004;
    #1;
    chk("hz_same_word", 64'(ld_st_hazard_e0), 64'd1);
    ld_va_e0 = 32'h0000_1008;
    #1;
    chk("hz_next_word", 64'(ld_st_hazard_e0), 64'd0);
    cycle();
    ld_req_e0  = 1'b0;
    mem_wr_rdy = 1'b1;
    run_until_ack(5);

    // reset while in MEM abandons the store; it is re-presented afterwards
    mem_wr_rdy = 1'b0;
    present(32'h0000_3000, 8'h3C, 64'h0F0F_0F0F_F0F0_F0F0);
    cycle();
    cycle();
    cycle();
    chk("rst_pre_mem_vld", 64'(mem_wr_vld), 64'd1);
    n_ack0     = n_ack;
    mem_wr_rdy = 1'b1;
    reset_n    = 1'b0;
    #1;
    chk("rst_mid_mem_vld", 64'(mem_wr_vld), 64'd0);
    chk("rst_mid_ack", 64'(rtr_st_ack_xx), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    prev_mem = 1'b0;
    run_until_ack(10);
    rtr_st_vld_xx = 1'b0;
    chk("rst_reack_count", 64'(n_ack - n_ack0), 64'd1);

    // randomized traffic
    for (int l = 0; l < 4; l++) begin
      tv[l] = ($urandom % 2) != 0;
      tt[l] = ($urandom % 2) != 0 ? TAG_W'(5) : TAG_W'(9);
    end
    for (int i = 0; i < 3000; i++) begin
      rtr_st_vld_xx  = ($urandom % 4) != 0;
      rtr_st_addr_xx = rand_addr();
      rtr_st_be_xx   = ($urandom % 8) == 0 ? 8'h00 : 8'($urandom);
      rtr_st_data_xx = {$urandom, $urandom};
      ld_req_e0      = ($urandom % 4) == 0;
      ld_va_e0       = ($urandom % 2) != 0 ? (rtr_st_addr_xx ^ 32'($urandom % 8)) : rand_addr();
      mem_wr_rdy     = ($urandom % 2) != 0;
      cycle();
    end
    rtr_st_vld_xx = 1'b0;
    ld_req_e0     = 1'b0;
    mem_wr_rdy    = 1'b1;
    repeat (10) cycle();
    chk("drain_idle", 64'(mem_wr_vld), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_st_port.md
DCACHE_ST_PORT -- requirements
Module: dcache_st_port

Interface
REQ-001 Parameter VA_W, default `VA_BITS from shared defines, virtual address width.
REQ-002 clk  in  1  single clock, all state rising-edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 rtr_st_vld_xx / rtr_st_be_xx / rtr_st_data_xx / rtr_st_addr_xx  in  1/8/64/VA_W  store request from store buffer; byte-lane-aligned data.
REQ-005 rtr_st_ack_xx  out  1  one-cycle pulse: request retired, store buffer may free entry.
REQ-006 ld_req_e0 / ld_va_e0  in  1/VA_W  load pipe owns D$ arrays this cycle; load address.
REQ-007 ld_st_hazard_e0  out  1  load hits an un-retired store to the same 8-byte word.
REQ-008 dc_tag_rd_en / dc_tag_idx  out  1/8  tag array read port.
REQ-009 dc_tag_vld / dc_tag  in  1/VA_W-13  tag read result, valid the cycle after dc_tag_rd_en.
REQ-010 dc_wr_en / dc_wr_idx / dc_wr_be / dc_wr_data  out  1/10/8/64  data array word write.
REQ-011 mem_wr_vld / mem_wr_addr / mem_wr_be / mem_wr_data  out  1/VA_W/8/64  write-through request to memory.
REQ-012 mem_wr_rdy  in  1  memory accepts; transfer when mem_wr_vld & mem_wr_rdy.

Function
REQ-013 D$ geometry SHALL be 8 KB direct-mapped, 32-byte lines: tag va[VA_W-1:13], line index va[12:5], word index va[12:3].
REQ-014 Policy SHALL be write-through, no-write-allocate: hit writes array and memory, miss writes memory only.
REQ-015 FSM SHALL have states IDLE, LOOKUP, WRITE, MEM.
REQ-016 IDLE: if rtr_st_vld_xx & ~ld_req_e0, assert dc_tag_rd_en with idx va[12:5], latch addr/be/data, go LOOKUP; otherwise stay (load has priority).
REQ-017 LOOKUP: hit = dc_tag_vld & (dc_tag == latched va[VA_W-1:13]); hit -> WRITE, miss -> MEM.
REQ-018 WRITE: if ~ld_req_e0, assert dc_wr_en with latched word index/be/data for exactly one cycle and go MEM; else stall in WRITE.
REQ-019 MEM: assert mem_wr_vld with latched addr/be/data; hold all four stable until mem_wr_rdy.
REQ-020 On MEM & mem_wr_rdy, rtr_st_ack_xx SHALL pulse the same cycle and FSM returns to IDLE.
REQ-021 Next request SHALL be sampled no earlier than the cycle after ack (one store in flight maximum).
REQ-022 ld_st_hazard_e0 = ld_req_e0 & ((state != IDLE & latched va[VA_W-1:3] == ld_va_e0[VA_W-1:3]) | (rtr_st_vld_xx & rtr_st_addr_xx[VA_W-1:3] == ld_va_e0[VA_W-1:3])).
REQ-023 be == 0 request SHALL traverse the FSM normally and be acked (no array/memory byte changes).
REQ-024 Latched request SHALL not change while state != IDLE regardless of input activity.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE and deassert rtr_st_ack_xx, dc_tag_rd_en, dc_wr_en, mem_wr_vld, ld_st_hazard-state terms.
REQ-026 Latched addr/be/data SHALL reset to zero.
REQ-027 Reset mid-operation SHALL abandon the store without ack; store buffer retains it.

Structure
REQ-028 Shared package SHALL hold FSM state enum, D$ geometry constants (index/offset/tag widths) and hit-compare helper.
REQ-029 One sub-module dc_st_hazard (REQ-022 comparator) is natural; remainder flat.

Verification
REQ-030 Hit: tag array holds tag for va 0x2008, store be 0x0F -> tag read cycle 1, dc_wr_en cycle 2 idx 0x001, mem write, ack same cycle as mem_wr_rdy.
REQ-031 Miss: dc_tag_vld=0 -> no dc_wr_en, mem_wr_vld cycle 2, ack on handshake.
REQ-032 Load conflict: ld_req_e0 high 3 cycles in IDLE and in WRITE -> no tag read/write during them; store completes after.
REQ-033 Backpressure: mem_wr_rdy low 5 cycles -> mem_wr_* stable, no ack until rdy.
REQ-034 Hazard: store to 0x1000 in MEM, load 0x1004 -> ld_st_hazard_e0=1; load 0x1008 -> 0.
REQ-035 Reset in MEM -> mem_wr_vld drops immediately, no ack, FSM IDLE; re-presented store completes.
